// File: rtl/zone_scheduler.sv
// zone_scheduler: four-zone irrigation sequencer with round-robin grant.
// Button presses are synchronized and queued in pending. One zone is watered
// at a time for its short or long duration. Every watering period is followed
// by a pump-off gap. An abort press cuts watering short, or clears the queue
// when no zone is watering.
// Ports:
//   CLOCK_50  : clock; all state changes on its rising edge
//   reset_n   : asynchronous active-low reset
//   req_n     : active-low zone request buttons (asynchronous)
//   abort_n   : active-low abort button (asynchronous)
//   valve     : one-hot open valve
//   pump      : pump enable, high exactly when a valve is open
//   zone      : index of the zone being watered
//   pending   : queued zone requests
//   busy_led  : high while watering or in the gap
//   idle_led  : high while idle
//   done      : one-cycle pulse when a zone completes its full duration
module zone_scheduler #(
  parameter int unsigned CLK_DIV   = 50000000,
  parameter int unsigned SHORT_SEC = 3,
  parameter int unsigned LONG_SEC  = 6,
  parameter logic [3:0]  LONG_MASK = 4'b1100,
  parameter int unsigned GAP_SEC   = 1
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [3:0] req_n,
  input  logic       abort_n,
  output logic [3:0] valve,
  output logic       pump,
  output logic [1:0] zone,
  output logic [3:0] pending,
  output logic       busy_led,
  output logic       idle_led,
  output logic       done
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WATER = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Synchronizer stages plus one history stage for falling-edge detection
  logic [3:0]    req_s1_q, req_s1_d, req_s2_q, req_s2_d, req_s3_q, req_s3_d;
  logic          abt_s1_q, abt_s1_d, abt_s2_q, abt_s2_d, abt_s3_q, abt_s3_d;
  logic [1:0]    state_q, state_d;
  logic [3:0]    valve_q, valve_d;
  logic          pump_q, pump_d;
  logic [1:0]    zone_q, zone_d;
  logic [3:0]    pending_q, pending_d;
  logic [1:0]    last_grant_q, last_grant_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          idle_q, idle_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    sec_q, sec_d;

  logic [3:0] req_press_c;
  logic       abort_press_c;
  logic [1:0] grant_c;
  logic [3:0] grant_oh_c;
  logic [3:0] dur_c;
  logic [3:0] gap_c;
  logic       tick_c;
  logic       water_end_c;
  logic       gap_end_c;

  // Synchronizer chain; a press is a synchronized high-to-low transition
  always_comb begin
    req_s1_d      = req_n;
    req_s2_d      = req_s1_q;
    req_s3_d      = req_s2_q;
    abt_s1_d      = abort_n;
    abt_s2_d      = abt_s1_q;
    abt_s3_d      = abt_s2_q;
    req_press_c   = req_s3_q & ~req_s2_q;
    abort_press_c = abt_s3_q & ~abt_s2_q;
  end

  // Round-robin search from last_grant+1; the lowest offset found wins
  always_comb begin
    logic [1:0] idx;
    grant_c = last_grant_q;
    for (int k = 3; k >= 0; k--) begin
      idx = last_grant_q + 2'(k + 1);
      if (pending_q[idx]) grant_c = idx;
    end
    grant_oh_c = 4'b0001 << grant_c;
  end

  // Durations in seconds; zero is treated as one
  always_comb begin
    dur_c = LONG_MASK[zone_q] ? 4'(LONG_SEC) : 4'(SHORT_SEC);
    if (dur_c == 4'd0) dur_c = 4'd1;
    gap_c = (4'(GAP_SEC) == 4'd0) ? 4'd1 : 4'(GAP_SEC);
    tick_c      = (presc_q == PW'(CLK_DIV - 1));
    water_end_c = tick_c && (sec_q == dur_c - 4'd1);
    gap_end_c   = tick_c && (sec_q == gap_c - 4'd1);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    valve_d      = valve_q;
    pump_d       = pump_q;
    zone_d       = zone_q;
    pending_d    = pending_q | req_press_c;
    last_grant_d = last_grant_q;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (abort_press_c) begin
          pending_d = req_press_c;
        end else if (pending_q != 4'd0) begin
          state_d      = ST_WATER;
          valve_d      = grant_oh_c;
          pump_d       = 1'b1;
          zone_d       = grant_c;
          pending_d    = (pending_q & ~grant_oh_c) | req_press_c;
          last_grant_d = grant_c;
        end
      end
      ST_WATER: begin
        // Abort wins over a coinciding expiry and suppresses done
        if (abort_press_c || water_end_c) begin
          state_d = ST_GAP;
          valve_d = 4'd0;
          pump_d  = 1'b0;
          done_d  = !abort_press_c;
        end
      end
      ST_GAP: begin
        if (abort_press_c) pending_d = req_press_c;
        if (gap_end_c) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        valve_d = 4'd0;
        pump_d  = 1'b0;
      end
    endcase

    // Timers restart on every state change and only run while busy
    presc_d = '0;
    sec_d   = 4'd0;
    if (state_d == state_q && state_q != ST_IDLE) begin
      presc_d = tick_c ? '0 : presc_q + PW'(1);
      sec_d   = tick_c ? sec_q + 4'd1 : sec_q;
    end

    busy_d = (state_d == ST_WATER) || (state_d == ST_GAP);
    idle_d = (state_d == ST_IDLE);
  end

  // State register
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      req_s1_q     <= 4'hF;
      req_s2_q     <= 4'hF;
      req_s3_q     <= 4'hF;
      abt_s1_q     <= 1'b1;
      abt_s2_q     <= 1'b1;
      abt_s3_q     <= 1'b1;
      state_q      <= ST_IDLE;
      valve_q      <= 4'd0;
      pump_q       <= 1'b0;
      zone_q       <= 2'd0;
      pending_q    <= 4'd0;
      last_grant_q <= 2'd3;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      idle_q       <= 1'b1;
      presc_q      <= '0;
      sec_q        <= 4'd0;
    end else begin
      req_s1_q     <= req_s1_d;
      req_s2_q     <= req_s2_d;
      req_s3_q     <= req_s3_d;
      abt_s1_q     <= abt_s1_d;
      abt_s2_q     <= abt_s2_d;
      abt_s3_q     <= abt_s3_d;
      state_q      <= state_d;
      valve_q      <= valve_d;
      pump_q       <= pump_d;
      zone_q       <= zone_d;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      idle_q       <= idle_d;
      presc_q      <= presc_d;
      sec_q        <= sec_d;
    end
  end

  assign valve    = valve_q;
  assign pump     = pump_q;
  assign zone     = zone_q;
  assign pending  = pending_q;
  assign busy_led = busy_q;
  assign idle_led = idle_q;
  assign done     = done_q;

endmodule

// File: tb/tb_zone_scheduler.sv
// Directed bench for zone_scheduler with CLK_DIV=10 (short 30, long 60, gap 10 cycles).
module tb_zone_scheduler;

  logic       CLOCK_50;
  logic       reset_n;
  logic [3:0] req_n;
  logic       abort_n;
  logic [3:0] valve;
  logic       pump;
  logic [1:0] zone;
  logic [3:0] pending;
  logic       busy_led;
  logic       idle_led;
  logic       done;

  int checks;
  int errors;

  zone_scheduler #(
    .CLK_DIV(10), .SHORT_SEC(3), .LONG_SEC(6), .LONG_MASK(4'b1100), .GAP_SEC(1)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .req_n(req_n), .abort_n(abort_n),
    .valve(valve), .pump(pump), .zone(zone), .pending(pending),
    .busy_led(busy_led), .idle_led(idle_led), .done(done)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
  endtask

  // Wait for a grant, then measure watering length, done pulse and gap length
  task automatic serve(input string tag, input logic [3:0] exp_valve,
                       input logic [1:0] exp_zone, input int exp_len);
    int n;
    n = 0;
    while (valve != exp_valve && n < 100) begin step(1); n++; end
    check({tag, "_grant"}, valve, exp_valve);
    check({tag, "_pump"}, pump, 1'b1);
    check({tag, "_zone"}, zone, exp_zone);
    n = 0;
    while (valve == exp_valve && n < 200) begin n++; step(1); end
    check({tag, "_len"}, n, exp_len);
    check({tag, "_done"}, done, 1'b1);
    n = 0;
    while (busy_led && !pump && n < 100) begin n++; step(1); end
    check({tag, "_gap"}, n, 10);
  endtask

  initial begin
    int  n;
    logic saw_done;
    checks  = 0;
    errors  = 0;
    req_n   = 4'hF;
    abort_n = 1'b1;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    step(2);
    check("rst_valve", valve, 4'd0);
    check("rst_pump", pump, 1'b0);
    check("rst_zone", zone, 2'd0);
    check("rst_pending", pending, 4'd0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy_led, 1'b0);
    check("rst_idle", idle_led, 1'b1);
    reset_n = 1'b1;
    step(1);

    // Single short zone: pending three edges after the press, valve one edge later
    req_n = 4'b1110;
    step(2);
    check("z0_pend_early", pending, 4'd0);
    step(1);
    check("z0_pend", pending, 4'b0001);
    check("z0_valve_early", valve, 4'd0);
    step(1);
    req_n = 4'hF;
    check("z0_pend_clr", pending, 4'd0);
    check("z0_busy", busy_led, 1'b1);
    serve("z0", 4'b0001, 2'd0, 30);
    check("z0_idle", idle_led, 1'b1);

    // Simultaneous presses after reset are served 0, 2, 3
    do_reset();
    req_n = 4'b0010;
    step(4);
    req_n = 4'hF;
    check("multi_pend", pending, 4'b1100);
    serve("m0", 4'b0001, 2'd0, 30);
    serve("m2", 4'b0100, 2'd2, 60);
    serve("m3", 4'b1000, 2'd3, 60);

    // Re-press of the watering zone queues it behind another request
    req_n = 4'b0111;
    step(4);
    req_n = 4'hF;
    fork
      serve("r3", 4'b1000, 2'd3, 60);
      begin
        step(12);
        req_n = 4'b0110;
        step(4);
        req_n = 4'hF;
        check("repress_pend", pending, 4'b1001);
      end
    join
    serve("r0", 4'b0001, 2'd0, 30);
    serve("r3b", 4'b1000, 2'd3, 60);

    // Abort 15 cycles into zone 2 watering
    req_n = 4'b1011;
    step(4);
    req_n = 4'hF;
    check("ab_valve_on", valve, 4'b0100);
    req_n = 4'b1101;
    step(4);
    req_n = 4'hF;
    step(10);
    abort_n  = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      saw_done = saw_done | done;
    end
    abort_n = 1'b1;
    check("ab_valve_off", valve, 4'd0);
    check("ab_pump_off", pump, 1'b0);
    check("ab_no_done", saw_done, 1'b0);
    check("ab_busy", busy_led, 1'b1);
    check("ab_pend_kept", pending, 4'b0010);
    n = 0;
    while (busy_led && !pump && n < 100) begin n++; step(1); end
    check("ab_gap", n, 10);
    serve("ab_next", 4'b0010, 2'd1, 30);

    // Abort in IDLE arriving one edge after pending=0110 appears
    req_n = 4'b1001;
    step(1);
    abort_n = 1'b0;
    step(2);
    req_n = 4'hF;
    check("ai_pend", pending, 4'b0110);
    check("ai_idle0", idle_led, 1'b1);
    step(1);
    abort_n = 1'b1;
    check("ai_clr", pending, 4'd0);
    check("ai_idle1", idle_led, 1'b1);
    step(5);
    check("ai_stay", idle_led, 1'b1);
    check("ai_valve", valve, 4'd0);

    // Abort and press on the same edge in IDLE: the press survives
    req_n   = 4'b1110;
    abort_n = 1'b0;
    step(3);
    req_n   = 4'hF;
    abort_n = 1'b1;
    check("as_pend", pending, 4'b0001);
    serve("as", 4'b0001, 2'd0, 30);

    // Reset asserted mid-watering acts without a clock edge
    req_n = 4'b0111;
    step(4);
    req_n = 4'hF;
    step(5);
    check("rw_valve_on", valve, 4'b1000);
    #2 reset_n = 1'b0;
    #1;
    check("rw_valve", valve, 4'd0);
    check("rw_pump", pump, 1'b0);
    check("rw_idle", idle_led, 1'b1);
    step(1);
    reset_n = 1'b1;
    step(3);
    check("rw_after_idle", idle_led, 1'b1);
    check("rw_after_pend", pending, 4'd0);
    check("rw_after_valve", valve, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
